// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MODULUS counter with up/down count, clear, validated load
// and a combinational terminal-count flag for enable-based cascading.
module bcd_mod_counter #(
    parameter int unsigned MODULUS   = 60,
    parameter int unsigned INIT_TENS = 0,
    parameter int unsigned INIT_ONES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       up_dn,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry,
    output logic       term,
    output logic       load_err
);

    localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);
    localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] RST_TENS = 4'(INIT_TENS);
    localparam logic [3:0] RST_ONES = 4'(INIT_ONES);
    localparam logic [7:0] MOD_VAL  = 8'(MODULUS);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       carry_q, carry_d;
    logic       load_err_q, load_err_d;

    logic       at_max;
    logic       at_zero;
    logic [7:0] ld_val;
    logic       ld_ok;

    always_comb begin
        at_max  = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
        at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
        ld_val  = ({4'd0, load_tens} * 8'd10) + {4'd0, load_ones};
        ld_ok   = (load_tens <= 4'd9) && (load_ones <= 4'd9) && (ld_val < MOD_VAL);
    end

    always_comb begin
        tens_d     = tens_q;
        ones_d     = ones_q;
        carry_d    = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            tens_d = '0;
            ones_d = '0;
        end else if (load) begin
            // a rejected load still wins priority, so a same-cycle tick is dropped
            if (ld_ok) begin
                tens_d = load_tens;
                ones_d = load_ones;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (tick) begin
            if (up_dn) begin
                if (at_max) begin
                    tens_d  = '0;
                    ones_d  = '0;
                    carry_d = 1'b1;
                end else if (ones_q == 4'd9) begin
                    ones_d = '0;
                    tens_d = tens_q + 4'd1;
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    tens_d  = MAX_TENS;
                    ones_d  = MAX_ONES;
                    carry_d = 1'b1;
                end else if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    tens_d = tens_q - 4'd1;
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tens_q     <= RST_TENS;
            ones_q     <= RST_ONES;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            carry_q    <= carry_d;
            load_err_q <= load_err_d;
        end
    end

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign carry    = carry_q;
    assign load_err = load_err_q;
    assign term     = up_dn ? at_max : at_zero;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: seconds/hours cascade plus a modulo-100 instance,
// compared every cycle against an integer-valued model, with directed literal checks.
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0, up_dn = 1'b1, clear = 1'b0, load = 1'b0;
    logic [3:0] lt = '0, lo = '0;
    logic       h_load = 1'b0;
    logic [3:0] h_lt = '0, h_lo = '0;
    logic       m_tick = 1'b0;
    logic       h_tick;

    logic [3:0] s_tens, s_ones, h_tens, h_ones, m_tens, m_ones;
    logic       s_carry, s_term, s_err, h_carry, h_term, h_err, m_carry, m_term, m_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign h_tick = tick & s_term;

    bcd_mod_counter #(.MODULUS(60), .INIT_TENS(0), .INIT_ONES(0)) u_sec (
        .clk(clk), .reset(rst_n), .tick(tick), .up_dn(up_dn), .clear(clear), .load(load),
        .load_tens(lt), .load_ones(lo), .tens(s_tens), .ones(s_ones), .carry(s_carry),
        .term(s_term), .load_err(s_err));

    bcd_mod_counter #(.MODULUS(24), .INIT_TENS(0), .INIT_ONES(0)) u_hr (
        .clk(clk), .reset(rst_n), .tick(h_tick), .up_dn(up_dn), .clear(clear), .load(h_load),
        .load_tens(h_lt), .load_ones(h_lo), .tens(h_tens), .ones(h_ones), .carry(h_carry),
        .term(h_term), .load_err(h_err));

    bcd_mod_counter #(.MODULUS(100), .INIT_TENS(9), .INIT_ONES(9)) u_m100 (
        .clk(clk), .reset(rst_n), .tick(m_tick), .up_dn(up_dn), .clear(clear), .load(load),
        .load_tens(lt), .load_ones(lo), .tens(m_tens), .ones(m_ones), .carry(m_carry),
        .term(m_term), .load_err(m_err));

    typedef struct packed {
        int v;
        bit c;
        bit e;
    } res_t;

    // Counter behaviour as plain integer arithmetic on the decimal value
    function automatic res_t mstep(input int v, input int md, input bit clr, input bit ld,
                                   input int dt, input int d1, input bit tk, input bit up);
        res_t r;
        r.v = v; r.c = 1'b0; r.e = 1'b0;
        if (clr) r.v = 0;
        else if (ld) begin
            if (dt <= 9 && d1 <= 9 && dt * 10 + d1 < md) r.v = dt * 10 + d1;
            else r.e = 1'b1;
        end else if (tk) begin
            if (up) begin
                if (v == md - 1) begin r.v = 0; r.c = 1'b1; end
                else r.v = v + 1;
            end else begin
                if (v == 0) begin r.v = md - 1; r.c = 1'b1; end
                else r.v = v - 1;
            end
        end
        return r;
    endfunction

    res_t ms = '{0, 1'b0, 1'b0};
    res_t mh = '{0, 1'b0, 1'b0};
    res_t mm = '{99, 1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms <= '{0, 1'b0, 1'b0};
            mh <= '{0, 1'b0, 1'b0};
            mm <= '{99, 1'b0, 1'b0};
        end else begin
            ms <= mstep(ms.v, 60, clear, load, int'(lt), int'(lo), tick, up_dn);
            mh <= mstep(mh.v, 24, clear, h_load, int'(h_lt), int'(h_lo),
                        tick && (up_dn ? ms.v == 59 : ms.v == 0), up_dn);
            mm <= mstep(mm.v, 100, clear, load, int'(lt), int'(lo), m_tick, up_dn);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sec_tens", int'(s_tens), ms.v / 10);
            chk("sec_ones", int'(s_ones), ms.v % 10);
            chk("sec_carry", int'(s_carry), int'(ms.c));
            chk("sec_err", int'(s_err), int'(ms.e));
            chk("sec_term", int'(s_term), int'(up_dn ? ms.v == 59 : ms.v == 0));
            chk("hr_tens", int'(h_tens), mh.v / 10);
            chk("hr_ones", int'(h_ones), mh.v % 10);
            chk("hr_carry", int'(h_carry), int'(mh.c));
            chk("hr_err", int'(h_err), int'(mh.e));
            chk("hr_term", int'(h_term), int'(up_dn ? mh.v == 23 : mh.v == 0));
            chk("m100_tens", int'(m_tens), mm.v / 10);
            chk("m100_ones", int'(m_ones), mm.v % 10);
            chk("m100_carry", int'(m_carry), int'(mm.c));
            chk("m100_err", int'(m_err), int'(mm.e));
            chk("m100_term", int'(m_term), int'(up_dn ? mm.v == 99 : mm.v == 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sval();
        return int'(s_tens) * 10 + int'(s_ones);
    endfunction

    function automatic int hval();
        return int'(h_tens) * 10 + int'(h_ones);
    endfunction

    initial begin
        int ncar;
        int r;
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_sec", sval(), 0);
        chk("rst_m100", int'(m_tens) * 10 + int'(m_ones), 99);
        chk("rst_carry", int'(s_carry | m_carry | h_carry), 0);
        chk("rst_err", int'(s_err | m_err | h_err), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // 60 ticks up: one wrap of the seconds stage, hours advance once
        up_dn = 1'b1; tick = 1'b1; m_tick = 1'b1;
        ncar = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 59) chk("term_at_59", int'(s_term), 1);
            step();
            if (i == 0) begin
                chk("m100_wrap_up", int'(m_tens) * 10 + int'(m_ones), 0);
                chk("m100_wrap_carry", int'(m_carry), 1);
                m_tick = 1'b0;
            end
            if (s_carry) ncar++;
        end
        tick = 1'b0;
        chk("up60_val", sval(), 0);
        chk("up60_carry_now", int'(s_carry), 1);
        chk("up60_carry_once", ncar, 1);
        chk("up60_hour", hval(), 1);

        // load 39, up to 40, down to 38
        load = 1'b1; lt = 4'd3; lo = 4'd9; step(); load = 1'b0;
        ncar = 0;
        tick = 1'b1; step(); chk("ld39_up", sval(), 40); ncar += int'(s_carry);
        up_dn = 1'b0; step(); chk("dn_39", sval(), 39); ncar += int'(s_carry);
        step(); chk("dn_38", sval(), 38); ncar += int'(s_carry);
        tick = 1'b0;
        chk("no_carry_3940", ncar, 0);

        // down-wrap from 00 on all stages
        load = 1'b1; lt = 4'd0; lo = 4'd0; h_load = 1'b1; h_lt = 4'd0; h_lo = 4'd0;
        step(); load = 1'b0; h_load = 1'b0;
        chk("term_dn_sec", int'(s_term), 1);
        chk("term_dn_hr", int'(h_term), 1);
        tick = 1'b1; m_tick = 1'b1; step(); tick = 1'b0; m_tick = 1'b0;
        chk("borrow_sec", sval(), 59);
        chk("borrow_hr", hval(), 23);
        chk("borrow_hr_carry", int'(h_carry), 1);
        chk("borrow_m100", int'(m_tens) * 10 + int'(m_ones), 99);

        // load validation
        up_dn = 1'b1;
        load = 1'b1; lt = 4'd1; lo = 4'd2; step();
        lt = 4'd6; lo = 4'd0; step();
        chk("rej60_err", int'(s_err), 1); chk("rej60_val", sval(), 12);
        lt = 4'd1; lo = 4'hA; tick = 1'b1; step(); tick = 1'b0;
        chk("rej1A_err", int'(s_err), 1); chk("rej1A_val", sval(), 12);
        lt = 4'd5; lo = 4'd9; step(); load = 1'b0;
        chk("acc59_err", int'(s_err), 0); chk("acc59_val", sval(), 59);

        // priority
        load = 1'b1; lt = 4'd4; lo = 4'd5; step();
        clear = 1'b1; lt = 4'd3; lo = 4'd3; tick = 1'b1; step(); clear = 1'b0;
        chk("clr_prio", sval(), 0); chk("clr_carry", int'(s_carry), 0);
        lt = 4'd1; lo = 4'd0; tick = 1'b0; step();
        lt = 4'd2; lo = 4'd2; tick = 1'b1; step(); tick = 1'b0; load = 1'b0;
        chk("ld_prio", sval(), 22);

        // cascade wrap at 23:59, then reset while carry is high
        for (int k = 0; k < 2; k++) begin
            load = 1'b1; lt = 4'd5; lo = 4'd9; h_load = 1'b1; h_lt = 4'd2; h_lo = 4'd3;
            step(); load = 1'b0; h_load = 1'b0;
            tick = 1'b1; step(); tick = 1'b0;
            chk("casc_sec", sval(), 0); chk("casc_hr", hval(), 0);
            chk("casc_carry", int'(s_carry & h_carry), 1);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_val", sval() + hval(), 0);
        chk("midrst_carry", int'(s_carry | h_carry), 0);
        step(); rst_n = 1'b1; step();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            clear  = (r < 3);
            load   = (r >= 3 && r < 10);
            lt     = 4'($urandom_range(0, 11));
            lo     = 4'($urandom_range(0, 11));
            tick   = ($urandom_range(0, 3) != 0);
            up_dn  = ($urandom_range(0, 2) != 0);
            m_tick = ($urandom_range(0, 1) != 0);
            h_load = ($urandom_range(0, 19) == 0);
            h_lt   = 4'($urandom_range(0, 3));
            h_lo   = 4'($urandom_range(0, 11));
            step();
        end
        clear = 1'b0; load = 1'b0; tick = 1'b0; m_tick = 1'b0; h_load = 1'b0;
        step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_mod_counter.md
Name: bcd_mod_counter

Overview:
Parametrised two-digit BCD modulo-N counter. It generalises the seconds counter so that one block serves as the seconds, minutes (N=60), hours (N=24/12) and any other clock-chain stage. It counts directly in BCD, advances only on a system-clock-rate enable pulse rather than a derived slow clock, and supports up/down counting, synchronous clear and a validated parallel load for time setting. A terminal-count output lets stages cascade with no ripple clocks.

Parameters:
MODULUS, 60, count range 0..MODULUS-1; legal values 2..100
INIT_TENS, 0, tens digit loaded at reset; must form a value below MODULUS
INIT_ONES, 0, ones digit loaded at reset; must form a value below MODULUS

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset; low forces the reset state immediately
tick  input  1  count enable; one count per clk cycle in which it is high
up_dn  input  1  1 = count up, 0 = count down; sampled with tick
clear  input  1  synchronous clear to 00
load  input  1  synchronous parallel load strobe
load_tens  input  4  BCD tens digit to load
load_ones  input  4  BCD ones digit to load
tens  output  4  registered BCD tens digit
ones  output  4  registered BCD ones digit
carry  output  1  registered one-cycle pulse on wrap
term  output  1  combinational terminal-count flag, for cascading
load_err  output  1  registered one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset=0, asynchronous): tens=INIT_TENS, ones=INIT_ONES, carry=0, load_err=0. Release is synchronous to the next clk edge; the first count can occur on the edge after release.
- Per-edge priority: clear > load > tick > hold.
- clear=1: tens=0, ones=0, carry=0. A tick in the same cycle is ignored.
- load=1 with both digits <=9 and value 10*load_tens+load_ones < MODULUS: digits take the loaded values; carry=0; load_err=0.
- load=1 with any digit >9 or value >= MODULUS: counter holds, load_err=1 for one cycle, and a tick in the same cycle is dropped.
- tick=1, up_dn=1:
  - if ones<9 and value<MODULUS-1: ones+1.
  - if ones==9 and value<MODULUS-1: ones=0, tens+1.
  - if value==MODULUS-1: tens=0, ones=0, carry=1.
- tick=1, up_dn=0:
  - if ones>0: ones-1.
  - if ones==0 and value>0: ones=9, tens-1.
  - if value==0: digits take the BCD of MODULUS-1, carry=1 (borrow).
- carry is high only in the cycle following a wrapping tick, i.e. coincident with the wrapped value appearing on tens/ones. It is 0 on every other edge, including consecutive non-wrapping ticks.
- term = (up_dn && value==MODULUS-1) || (!up_dn && value==0). It is a pure function of current state and up_dn, independent of tick. Cascade rule: next stage tick = this tick & term, which wraps both stages on the same edge.
- Latency: one clk from tick/clear/load to the new digits.
- Value is always kept in 0..MODULUS-1 with each digit in 0..9. No path may produce a non-BCD digit.
- MODULUS=100: wrap occurs from 99 to 00 (up) and from 00 to 99 (down).
- reset asserted mid-count overrides everything, including any carry pulse in progress.

Test Plan:
- Reset then 60 ticks up, MODULUS=60 -> 00,01..09,10..59,00; carry=1 exactly once, in the cycle showing 00; term=1 only while 59 is held.
- Load 3/9, then tick up -> 40; then tick down twice -> 39, 38; carry never asserted.
- From 00, tick down, MODULUS=24 -> 23 with carry=1; term=1 before the tick (up_dn=0, value 0).
- Load 6/0 with MODULUS=60, then load 1/A -> both rejected, load_err pulses, value unchanged; load 5/9 -> accepted, value 59.
- Simultaneous clear+load+tick at 45 -> 00, carry=0; load+tick at 10 with load 2/2 -> 22, tick ignored.
- Cascade two instances (60, 24) with the hour tick = sec tick & term, start 23/59, one tick -> both 00, both carry pulse same cycle; reset low mid-count -> immediate 00, carry 0.
